// File: rtl/data_mem_pkg.sv
// Shared types and default geometry for the data-memory backing store.
package data_mem_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned LINE_OFS_W     = $clog2(DEF_LINE_WORDS);
  localparam int unsigned LINE_W         = DEF_DATA_W * DEF_LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } data_mem_state_e;

endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter with a combinational zero flag, used to time memory latency.
module mem_latency_ctr #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/data_mem_backing.sv
// Main-memory responder servicing cache line fills and write-throughs after a fixed latency.
// Optional request statistics are enabled with DATA_MEM_STATS_EN.
module data_mem_backing
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_req,
  input  logic                         mem_we,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
  output logic                         mem_ready,
  output logic                         mem_busy
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [15:0]                  rd_count,
  output logic [15:0]                  wr_count
`endif
);

  localparam int unsigned OFS_W   = $clog2(LINE_WORDS);
  localparam int unsigned RDATA_W = DATA_W * LINE_WORDS;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  data_mem_state_e state_q, state_d;

  logic [ADDR_W-1:0]  addr_q;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               accept;
  logic               ctr_load;
  logic               ctr_dec;
  logic [CNT_W-1:0]   ctr_val;
  logic               ctr_zero;
  logic               commit_rd;
  logic               commit_wr;
  logic [ADDR_W-1:0]  line_base;
  logic [RDATA_W-1:0] line_c;

  mem_latency_ctr #(
    .W (CNT_W)
  ) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .zero_c   (ctr_zero)
  );

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    ctr_val   = '0;
    commit_rd = 1'b0;
    commit_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          accept   = 1'b1;
          ctr_load = 1'b1;
          ctr_val  = mem_we ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
          state_d  = mem_we ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ctr_zero) begin
          commit_rd = 1'b1;
          state_d   = RESP;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      WR_WAIT: begin
        if (ctr_zero) begin
          commit_wr = 1'b1;
          state_d   = RESP;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      mem_ready <= (state_d == RESP);
      mem_busy  <= (state_d != IDLE);
      if (commit_rd) begin
        mem_rdata <= line_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      we_q    <= mem_we;
      wdata_q <= mem_wdata;
    end
  end

  // Words are stored relative to their address so an all-zero array reads back as word i = i
  always_ff @(posedge clk) begin
    if (commit_wr && !reset) begin
      mem_q[addr_q] <= wdata_q ^ DATA_W'(addr_q);
    end
  end

  assign line_base = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  always_comb begin
    line_c = '0;
    for (int w = 0; w < int'(LINE_WORDS); w++) begin
      line_c[w*DATA_W +: DATA_W] = mem_q[line_base | ADDR_W'(w)] ^ DATA_W'(line_base | ADDR_W'(w));
    end
  end

`ifdef DATA_MEM_STATS_EN
  // Completed-request counters, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state_q == RESP) begin
      if (we_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_backing.sv
// Self-checking bench for data_mem_backing: edge-count reference model plus directed literal checks.
module tb_data_mem_backing;
  import data_mem_pkg::*;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 1 << LINE_OFS_W;
  localparam int RD_LAT     = 4;
  localparam int WR_LAT     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_busy;
`ifdef DATA_MEM_STATS_EN
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;
`endif

  int checks = 0;
  int errors = 0;

  data_mem_backing #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_busy  (mem_busy)
`ifdef DATA_MEM_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: tracks the accept edge of each request and derives outputs by edge arithmetic
  logic [DATA_W-1:0] mdl_mem [1 << ADDR_W];
  logic [LINE_W-1:0] e_rdata = '0;
  bit                e_ready = 1'b0;
  bit                e_busy  = 1'b0;
  bit                mdl_on  = 1'b0;
  bit                have_op = 1'b0;
  bit                op_we   = 1'b0;
  logic [ADDR_W-1:0] op_addr = '0;
  logic [DATA_W-1:0] op_wd   = '0;
  int                edge_n  = 0;
  int                acc_edge = 0;
  int                done_edge = 0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mdl_mem[i] = DATA_W'(i);
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        have_op = 1'b0;
        e_ready = 1'b0;
        e_busy  = 1'b0;
        e_rdata = '0;
        mdl_on  = 1'b1;
      end else begin
        if (have_op && edge_n == done_edge) begin
          if (op_we) begin
            mdl_mem[op_addr] = op_wd;
          end else begin
            for (int w = 0; w < LINE_WORDS; w++)
              e_rdata[w*DATA_W +: DATA_W] = mdl_mem[((int'(op_addr) >> LINE_OFS_W) << LINE_OFS_W) + w];
          end
        end
        if (mem_req && (!have_op || edge_n >= done_edge + 2)) begin
          have_op   = 1'b1;
          acc_edge  = edge_n;
          op_we     = mem_we;
          op_addr   = mem_addr;
          op_wd     = mem_wdata;
          done_edge = edge_n + (mem_we ? WR_LAT : RD_LAT);
        end
        e_busy  = have_op && edge_n >= acc_edge && edge_n <= done_edge;
        e_ready = have_op && edge_n == done_edge;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (mdl_on) begin
        check("cyc_ready", LINE_W'(mem_ready), LINE_W'(e_ready));
        check("cyc_busy",  LINE_W'(mem_busy),  LINE_W'(e_busy));
        check("cyc_rdata", mem_rdata, e_rdata);
      end
    end
  end

  task automatic wait_ready(output int n);
    bit ok = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=no_ready expected=ready_within_40");
    end
  endtask

  task automatic txn(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd, output int n);
    @(negedge clk);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    wait_ready(n);
    mem_req = 1'b0;
  endtask

  initial begin
    int  n;
    int  busy_n;
    int  rdy_at;
    bit  rdy_seen;

    repeat (2) @(negedge clk);
    check("rst_ready", LINE_W'(mem_ready), LINE_W'(0));
    check("rst_busy",  LINE_W'(mem_busy),  LINE_W'(0));
    check("rst_rdata", mem_rdata, LINE_W'(0));
    reset = 1'b0;

    // First line fill: ready timing and busy window
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h000;
    busy_n = 0; rdy_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_busy) busy_n++;
      if (mem_ready && rdy_at == 0) begin
        rdy_at  = i;
        mem_req = 1'b0;
      end
    end
    check("rd0_ready_at", LINE_W'(rdy_at), LINE_W'(5));
    check("rd0_busy_cycles", LINE_W'(busy_n), LINE_W'(5));
    check("rd0_line", mem_rdata, {32'h3, 32'h2, 32'h1, 32'h0});

    // Write-through then read of the same line with low address bits set
    txn(1'b1, 10'h000, 32'hDEADBEEF, n);
    check("wr0_latency", LINE_W'(n), LINE_W'(WR_LAT + 1));
    txn(1'b0, 10'h002, 32'h0, n);
    check("rd2_line", mem_rdata, {32'h3, 32'h2, 32'h1, 32'hDEADBEEF});

    // Reset in the middle of a write aborts it
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'h3FF; mem_wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    reset = 1'b1; mem_req = 1'b0;
    rdy_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mem_ready) rdy_seen = 1'b1;
    end
    check("rst_mid_rdata", mem_rdata, LINE_W'(0));
    check("rst_mid_busy", LINE_W'(mem_busy), LINE_W'(0));
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready) rdy_seen = 1'b1;
    end
    check("rst_mid_no_ready", LINE_W'(rdy_seen), LINE_W'(0));
    txn(1'b0, 10'h3FC, 32'h0, n);
    check("rd3fc_line", mem_rdata, {32'h3FF, 32'h3FE, 32'h3FD, 32'h3FC});

    // Reset and request together: nothing accepted
    @(negedge clk);
    reset = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h020;
    @(negedge clk);
    reset = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check("rst_req_busy", LINE_W'(mem_busy), LINE_W'(0));

    // Request held high across two reads; address change while busy is ignored
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h004;
    wait_ready(n);
    check("rd4_line", mem_rdata, {32'h7, 32'h6, 32'h5, 32'h4});
    mem_addr = 10'h008;
    @(negedge clk);
    check("rd4_pulse_width", LINE_W'(mem_ready), LINE_W'(0));
    @(negedge clk);
    mem_addr = 10'h100;
    check("rd8_busy", LINE_W'(mem_busy), LINE_W'(1));
    wait_ready(n);
    check("rd8_line", mem_rdata, {32'hB, 32'hA, 32'h9, 32'h8});
    mem_req = 1'b0;
    @(negedge clk);
    check("rd8_pulse_width", LINE_W'(mem_ready), LINE_W'(0));

    // Read data holds through a write-through
    txn(1'b0, 10'h010, 32'h0, n);
    check("rd10_line", mem_rdata, {32'h13, 32'h12, 32'h11, 32'h10});
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'h011; mem_wdata = 32'h12345678;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rdata_hold", mem_rdata, {32'h13, 32'h12, 32'h11, 32'h10});
      if (mem_ready) break;
    end
    mem_req = 1'b0;
    txn(1'b0, 10'h010, 32'h0, n);
    check("rd10_after_wr", mem_rdata, {32'h13, 32'h12, 32'h12345678, 32'h10});

`ifdef DATA_MEM_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("stats_rst_rd", LINE_W'(rd_count), LINE_W'(0));
    txn(1'b0, 10'h040, 32'h0, n);
    txn(1'b1, 10'h041, 32'hA5A5A5A5, n);
    txn(1'b0, 10'h044, 32'h0, n);
    txn(1'b1, 10'h045, 32'h5A5A5A5A, n);
    txn(1'b0, 10'h040, 32'h0, n);
    @(negedge clk);
    check("stats_rd", LINE_W'(rd_count), LINE_W'(3));
    check("stats_wr", LINE_W'(wr_count), LINE_W'(2));
    check("stats_line", mem_rdata, {32'h43, 32'h42, 32'hA5A5A5A5, 32'h40});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("stats_clr_rd", LINE_W'(rd_count), LINE_W'(0));
    check("stats_clr_wr", LINE_W'(wr_count), LINE_W'(0));
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
